psum_adder_sched: RTL and testbench
===================================

// Module: psum_adder_sched
// PURPOSE
//   Layer scheduler for the psum adder/threshold pipeline. Per layer: latches the output
//   geometry, accepts one PE-array psum vector per handshake, and drives the adder's
//   i_valid/address_in with the linear ofmap BRAM address. After the last beat it pulses
//   layer_finish, waits for the adder's o_last, then reports done. Sits between PE array and adder.
// PARAMETERS
//   OFMAPS_BRAM_ADDR_WIDTH  12  ofmap BRAM address width (matches adder address_in)
//   DIM_WIDTH                8  width of each geometry field (out_w, out_h, out_ch)
// PORTS
//   clk               in   1    clock
//   rst_n             in   1    async active-low reset
//   start             in   1    1-cycle layer start; honoured only in IDLE
//   cfg_out_w         in   DIM_WIDTH               ofmap width (columns)
//   cfg_out_h         in   DIM_WIDTH               ofmap height (rows)
//   cfg_out_ch        in   DIM_WIDTH               output channels per pixel
//   cfg_base_addr     in   OFMAPS_BRAM_ADDR_WIDTH  first ofmap address
//   pe_valid          in   1    PE array has a psum vector this cycle
//   pe_ready          out  1    scheduler accepts vector (beat = pe_valid & pe_ready)
//   adder_valid       out  1    to adder i_valid
//   adder_addr        out  OFMAPS_BRAM_ADDR_WIDTH  to adder address_in
//   adder_layer_finish out 1    to adder layer_finish (1-cycle pulse)
//   adder_last        in   1    from adder o_last
//   busy              out  1    high in any state except IDLE
//   done              out  1    1-cycle pulse: layer fully drained through adder
// BEHAVIOUR
//   Reset: state=IDLE; pe_ready, adder_valid, adder_layer_finish, busy, done = 0; adder_addr = 0;
//     counters cleared. Reset mid-layer aborts immediately; no finish/done is produced.
//   States: IDLE, RUN, FIN, DRAIN, DONE.
//   IDLE: on start latch cfg_* and base into shadow regs, clear ch/col/row counters and
//     addr_cnt=base. If any of w,h,ch == 0 -> FIN, else -> RUN. start in other states ignored.
//   RUN: pe_ready=1 (decoded from state reg). On beat: next cycle adder_valid=1,
//     adder_addr=addr_cnt (1-cycle registered latency); addr_cnt+=1 modulo 2^ADDR_WIDTH
//     (wrap-around, no error). Loop order: ch innermost, then col, then row. No beat:
//     adder_valid=0, adder_addr holds last value. Beat with ch=ch-1,col=w-1,row=h-1 -> FIN.
//   FIN: pe_ready=0; adder_layer_finish=1 exactly this cycle, i.e. the cycle after the
//     final adder_valid (or 2 cycles after start for zero geometry) -> DRAIN.
//   DRAIN: wait for adder_last=1 -> DONE. adder_last seen in any other state is ignored.
//   DONE: done=1 for one cycle -> IDLE. busy falls with done's following cycle.
//   Beats per layer = w*h*ch exactly; counters compare against latched cfg, so cfg_* may
//     change freely while busy. pe_valid outside RUN is not consumed.
//   Simultaneous start and adder_last in IDLE: start taken, adder_last ignored.
// TESTING
//   1 w=2,h=2,ch=2,base=0x100, pe_valid held 1 -> adder_valid 8 consecutive cycles, addr
//     0x100..0x107; adder_layer_finish next cycle; done 1 cycle after adder_last.
//   2 same cfg, pe_valid toggled 1/0 -> 8 valid beats with gaps, addresses contiguous, addr
//     held during gaps; finish only after 8th beat.
//   3 w=0 (h=3,ch=4) start -> no adder_valid, adder_layer_finish 2 cycles after start, then
//     done after adder_last.
//   4 w=1,h=1,ch=4,base=0xFFE -> addresses 0xFFE,0xFFF,0x000,0x001; no error.
//   5 second start pulse mid-RUN and cfg_out_ch changed mid-RUN -> ignored; beat count unchanged.
//   6 rst_n low after 3 beats -> all outputs 0 asynchronously; new start runs a full clean layer.

Source files
------------

// File: rtl/psum_adder_sched.sv
// psum_adder_sched: per-layer scheduler feeding PE-array psum beats to the adder with linear ofmap addresses
module psum_adder_sched #(
  parameter int OFMAPS_BRAM_ADDR_WIDTH = 12,
  parameter int DIM_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [DIM_WIDTH-1:0]              cfg_out_w,
  input  logic [DIM_WIDTH-1:0]              cfg_out_h,
  input  logic [DIM_WIDTH-1:0]              cfg_out_ch,
  input  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic                              pe_valid,
  output logic                              pe_ready,
  output logic                              adder_valid,
  output logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] adder_addr,
  output logic                              adder_layer_finish,
  input  logic                              adder_last,
  output logic                              busy,
  output logic                              done
);
  typedef enum logic [2:0] {IDLE, RUN, FIN, DRAIN, DONE} state_t;
  state_t state;
  logic [DIM_WIDTH-1:0] w_r, h_r, ch_r, ch_c, col_c, row_c;
  logic [OFMAPS_BRAM_ADDR_WIDTH-1:0] addr_cnt;
  logic beat, last_ch, last_col, last_row;
  assign pe_ready = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign beat = pe_valid & pe_ready;
  assign last_ch = ch_c == ch_r - DIM_WIDTH'(1);
  assign last_col = col_c == w_r - DIM_WIDTH'(1);
  assign last_row = row_c == h_r - DIM_WIDTH'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w_r <= '0;
      h_r <= '0;
      ch_r <= '0;
      ch_c <= '0;
      col_c <= '0;
      row_c <= '0;
      addr_cnt <= '0;
      adder_valid <= 1'b0;
      adder_addr <= '0;
      adder_layer_finish <= 1'b0;
    end else begin
      adder_valid <= beat;
      adder_layer_finish <= state == FIN;
      if (beat) begin
        adder_addr <= addr_cnt;
        addr_cnt <= addr_cnt + OFMAPS_BRAM_ADDR_WIDTH'(1);
        ch_c <= last_ch ? '0 : ch_c + DIM_WIDTH'(1);
        col_c <= last_ch ? (last_col ? '0 : col_c + DIM_WIDTH'(1)) : col_c;
        row_c <= (last_ch && last_col) ? row_c + DIM_WIDTH'(1) : row_c;
      end
      case (state)
        IDLE: if (start) begin
          w_r <= cfg_out_w;
          h_r <= cfg_out_h;
          ch_r <= cfg_out_ch;
          ch_c <= '0;
          col_c <= '0;
          row_c <= '0;
          addr_cnt <= cfg_base_addr;
          state <= (cfg_out_w == '0 || cfg_out_h == '0 || cfg_out_ch == '0) ? FIN : RUN;
        end
        RUN: if (beat && last_ch && last_col && last_row) state <= FIN;
        FIN: state <= DRAIN;
        DRAIN: if (adder_last) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_adder_sched.sv
// tb_psum_adder_sched: directed self-checking bench for psum_adder_sched
module tb_psum_adder_sched;
  logic clk = 0, rst_n = 0, start = 0, pe_valid = 0, adder_last = 0;
  logic [7:0] cfg_out_w = 0, cfg_out_h = 0, cfg_out_ch = 0;
  logic [11:0] cfg_base_addr = 0;
  logic pe_ready, adder_valid, adder_layer_finish, busy, done;
  logic [11:0] adder_addr;
  int pass = 0, total = 0, cyc = 0;
  int fin_cnt = 0, fin_cyc = 0, done_cnt = 0, done_cyc = 0, last_v_cyc = 0, hold_err = 0;
  logic [11:0] q[$];
  logic [11:0] prev_addr = 0;
  logic prev_rst = 0, tog = 0;
  int s, qb, f0, d0;
  psum_adder_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_out_w(cfg_out_w), .cfg_out_h(cfg_out_h), .cfg_out_ch(cfg_out_ch),
    .cfg_base_addr(cfg_base_addr), .pe_valid(pe_valid), .pe_ready(pe_ready),
    .adder_valid(adder_valid), .adder_addr(adder_addr),
    .adder_layer_finish(adder_layer_finish), .adder_last(adder_last),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (adder_valid) begin
      q.push_back(adder_addr);
      last_v_cyc = cyc;
    end
    if (rst_n && prev_rst && !adder_valid && adder_addr !== prev_addr) hold_err++;
    prev_addr = adder_addr;
    prev_rst = rst_n;
    if (adder_layer_finish) begin
      fin_cnt++;
      fin_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start_layer(input int w, input int h, input int ch, input int base);
    cfg_out_w = 8'(w);
    cfg_out_h = 8'(h);
    cfg_out_ch = 8'(ch);
    cfg_base_addr = 12'(base);
    qb = q.size();
    f0 = fin_cnt;
    s = cyc;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic wait_fin(input string tag);
    for (int i = 0; i < 100 && fin_cnt == f0; i++) begin
      if (tog) pe_valid = ~pe_valid;
      tick();
    end
    pe_valid = 0;
    chk({tag, "_fin_once"}, fin_cnt, f0 + 1);
    chk({tag, "_pe_ready_low"}, int'(pe_ready), 0);
  endtask
  task automatic check_addrs(input string tag, input int base, input int n);
    chk({tag, "_beats"}, q.size() - qb, n);
    for (int i = 0; i < n; i++)
      if (qb + i < q.size()) chk($sformatf("%s_addr%0d", tag, i), int'(q[qb + i]), (base + i) & 12'hFFF);
    if (n > 0) chk({tag, "_fin_after_last"}, fin_cyc, last_v_cyc + 1);
  endtask
  task automatic drain(input string tag);
    int lc;
    d0 = done_cnt;
    chk({tag, "_busy_drain"}, int'(busy), 1);
    lc = cyc;
    adder_last = 1;
    tick();
    adder_last = 0;
    tick();
    tick();
    chk({tag, "_done_once"}, done_cnt, d0 + 1);
    chk({tag, "_done_cyc"}, done_cyc, lc + 1);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask
  initial begin
    #12;
    chk("rst_outs", int'({pe_ready, adder_valid, adder_layer_finish, busy, done}), 0);
    chk("rst_addr", int'(adder_addr), 0);
    tick();
    rst_n = 1;
    tick();
    // 1: continuous beats
    pe_valid = 1;
    start_layer(2, 2, 2, 'h100);
    chk("t1_busy", int'(busy), 1);
    wait_fin("t1");
    check_addrs("t1", 'h100, 8);
    chk("t1_last_valid_cyc", last_v_cyc, s + 9);
    drain("t1");
    // 2: toggled pe_valid
    pe_valid = 1;
    tog = 1;
    start_layer(2, 2, 2, 'h100);
    wait_fin("t2");
    tog = 0;
    check_addrs("t2", 'h100, 8);
    chk("t2_addr_hold", hold_err, 0);
    drain("t2");
    // 3: zero geometry, adder_last alongside start and in FIN
    d0 = done_cnt;
    adder_last = 1;
    start_layer(0, 3, 4, 'h050);
    tick();
    adder_last = 0;
    tick();
    chk("t3_fin_cnt", fin_cnt, f0 + 1);
    chk("t3_fin_cyc", fin_cyc, s + 2);
    chk("t3_no_valid", q.size() - qb, 0);
    chk("t3_no_early_done", done_cnt, d0);
    drain("t3");
    // 4: address wrap
    pe_valid = 1;
    start_layer(1, 1, 4, 'hFFE);
    wait_fin("t4");
    check_addrs("t4", 'hFFE, 4);
    drain("t4");
    // 5: start and cfg change mid-run ignored
    pe_valid = 1;
    start_layer(2, 2, 2, 'h020);
    tick();
    tick();
    start = 1;
    cfg_out_ch = 5;
    cfg_out_w = 0;
    tick();
    start = 0;
    wait_fin("t5");
    check_addrs("t5", 'h020, 8);
    drain("t5");
    // 6: async reset mid-layer, then clean layer
    pe_valid = 1;
    start_layer(2, 2, 2, 'h300);
    tick();
    tick();
    tick();
    chk("t6_pre_valid", int'(adder_valid), 1);
    chk("t6_pre_addr", int'(adder_addr), 'h302);
    f0 = fin_cnt;
    d0 = done_cnt;
    #2 rst_n = 0;
    #1;
    chk("t6_rst_outs", int'({pe_ready, adder_valid, adder_layer_finish, busy, done}), 0);
    chk("t6_rst_addr", int'(adder_addr), 0);
    tick();
    rst_n = 1;
    pe_valid = 0;
    tick();
    tick();
    tick();
    chk("t6_no_fin", fin_cnt, f0);
    chk("t6_no_done", done_cnt, d0);
    pe_valid = 1;
    start_layer(2, 2, 2, 'h300);
    wait_fin("t6");
    check_addrs("t6", 'h300, 8);
    drain("t6");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
